// File: rtl/cla_pipe_accum.sv
// cla_pipe_accum
//   Segment-pipelined wide carry-lookahead adder / accumulator. The operand
//   word is cut into SEG slices of WIDTH/SEG bits. Each pipeline stage sums one
//   slice with a parallel-prefix (Kogge-Stone) CLA. The carry is registered
//   between stages. Lower result slices ride along already finished. Upper
//   operand slices ride along unconsumed, so every slice of a beat leaves the
//   last stage together.
//
//   op: 00 A+B, 01 A-B (B inverted, carry-in 1), 10 ACC+=A, 11 ACC=A
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears pipeline, result, ACC)
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle when high (pipeline may advance)
//   op         operation select, see above
//   a, b       operands (b ignored for op 10/11)
//   out_valid  result valid
//   out_ready  downstream takes the result
//   res        result / new ACC value
//   cout       carry out of MSB (inverted borrow for subtract, 0 for load)
module cla_pipe_accum #(
  parameter int WIDTH = 512,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  localparam int SEG_SAFE = (SEG > 0) ? SEG : 1;
  localparam int SW       = WIDTH / SEG_SAFE;

  if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_param
    $error("cla_pipe_accum: SEG must be >= 1 and divide WIDTH");
  end

  // Parallel-prefix slice adder. Carry-in is folded into bit 0's generate, so
  // the prefix generate of bit i is the carry out of bit i.
  function automatic logic [SW:0] cla_add(input logic [SW-1:0] x,
                                          input logic [SW-1:0] y,
                                          input logic          ci);
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW-1:0] gg;
    logic [SW-1:0] pp;
    logic [SW-1:0] s;
    g     = x & y;
    p     = x ^ y;
    gg    = g;
    pp    = p;
    gg[0] = g[0] | (p[0] & ci);
    for (int d = 1; d < SW; d = d * 2) begin
      // Descending index keeps the lower operands at their previous level.
      for (int i = SW - 1; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    s[0] = p[0] ^ ci;
    for (int i = 1; i < SW; i++) begin
      s[i] = p[i] ^ gg[i-1];
    end
    return {gg[SW-1], s};
  endfunction

  // Index 0 is the input register; index k (1..SEG) holds the beat after
  // slice k-1 has been summed. Index SEG drives the outputs directly.
  logic             vld_p [0:SEG];
  logic [1:0]       op_p  [0:SEG];
  logic [WIDTH-1:0] a_p   [0:SEG];
  logic [WIDTH-1:0] b_p   [0:SEG];
  logic [WIDTH-1:0] s_p   [0:SEG];
  logic             c_p   [0:SEG];
  logic [SW-1:0]    acc_q [0:SEG-1];

  logic adv;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p[SEG];
  assign res       = s_p[SEG];
  assign cout      = c_p[SEG];

  // ---- stage p0: input register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p[0] <= 1'b0;
      op_p[0]  <= 2'b00;
      a_p[0]   <= '0;
      b_p[0]   <= '0;
      s_p[0]   <= '0;
      c_p[0]   <= 1'b0;
    end else if (adv) begin
      vld_p[0] <= in_valid;
      op_p[0]  <= op;
      a_p[0]   <= a;
      b_p[0]   <= (op == 2'b01) ? ~b : b;
      s_p[0]   <= '0;
      c_p[0]   <= (op == 2'b01);
    end
  end

  for (genvar k = 1; k <= SEG; k++) begin : g_seg
    localparam int LO = (k - 1) * SW;
    // Finished slices below LO are kept; consumed operand slices are cleared.
    localparam logic [WIDTH-1:0] LOW_M  = ~({WIDTH{1'b1}} << LO);
    localparam logic [WIDTH-1:0] HIGH_M = {WIDTH{1'b1}} << (LO + SW);

    logic [SW-1:0] a_sl;
    logic [SW-1:0] opb;
    logic [SW-1:0] sum;
    logic          co;

    always_comb begin
      a_sl      = a_p[k-1][LO +: SW];
      opb       = (op_p[k-1] == 2'b10) ? acc_q[k-1] : b_p[k-1][LO +: SW];
      {co, sum} = cla_add(a_sl, opb, c_p[k-1]);
      if (op_p[k-1] == 2'b11) begin
        sum = a_sl;
        co  = 1'b0;
      end
    end

    // ---- stage p(k): slice k-1 summed, ACC slice k-1 updated ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p[k]   <= 1'b0;
        op_p[k]    <= 2'b00;
        a_p[k]     <= '0;
        b_p[k]     <= '0;
        s_p[k]     <= '0;
        c_p[k]     <= 1'b0;
        acc_q[k-1] <= '0;
      end else if (adv) begin
        vld_p[k] <= vld_p[k-1];
        op_p[k]  <= op_p[k-1];
        a_p[k]   <= a_p[k-1] & HIGH_M;
        b_p[k]   <= b_p[k-1] & HIGH_M;
        s_p[k]   <= (s_p[k-1] & LOW_M) | (WIDTH'(sum) << LO);
        c_p[k]   <= co;
        if (vld_p[k-1] && op_p[k-1][1]) begin
          acc_q[k-1] <= sum;
        end
      end
    end
  end

endmodule
